// File: rtl/instr_pack_pkg.sv
// Shared definitions for instruction packing: immediate format encodings
// (also used by the decode-side extender and control) and FIFO depth.
package instr_pack_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } immsrc_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/instr_pack_imm_pack.sv
// Combinational field packer: inverse of the immediate extender, plus the
// optional immediate range check enabled by IMM_RANGE_CHECK_EN.
module imm_pack
  import instr_pack_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [1:0]          immsrc,
  input  logic signed [N-1:0] imm,
  input  logic [6:0]          opcode,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [2:0]          funct3,
  output logic [N-1:0]        instr,
  output logic                err
);

  logic [31:0] word;

  always_comb begin
    word      = '0;
    word[6:0] = opcode;
    case (immsrc_t'(immsrc))
      IMM_I: begin
        word[31:20] = imm[11:0];
        word[19:15] = rs1;
        word[14:12] = funct3;
        word[11:7]  = rd;
      end
      IMM_S: begin
        word[31:25] = imm[11:5];
        word[24:20] = rs2;
        word[19:15] = rs1;
        word[14:12] = funct3;
        word[11:7]  = imm[4:0];
      end
      IMM_B: begin
        word[31]    = imm[12];
        word[30:25] = imm[10:5];
        word[24:20] = rs2;
        word[19:15] = rs1;
        word[14:12] = funct3;
        word[11:8]  = imm[4:1];
        word[7]     = imm[11];
      end
      default: begin
        word[31]    = imm[20];
        word[30:21] = imm[10:1];
        word[20]    = imm[11];
        word[19:12] = imm[19:12];
        word[11:7]  = rd;
      end
    endcase
    instr       = '0;
    instr[31:0] = word;
  end

`ifdef IMM_RANGE_CHECK_EN
  // A value fits w signed bits when everything from bit w-1 upward is pure sign.
  function automatic logic fits(input logic signed [N-1:0] v, input int w);
    logic signed [N-1:0] t;
    t = v >>> (w - 1);
    return (t == '0) || (t == '1);
  endfunction

  always_comb begin
    case (immsrc_t'(immsrc))
      IMM_I, IMM_S: err = !fits(imm, 12);
      IMM_B:        err = !fits(imm, 13) || imm[0];
      default:      err = !fits(imm, 21) || imm[0];
    endcase
  end
`else
  logic unused_imm;
  assign unused_imm = ^imm[N-1:21];
  assign err        = 1'b0;
`endif

endmodule

// File: rtl/instr_pack.sv
// Instruction packer top: packs fields via imm_pack into a 2-entry FIFO with
// valid/ready handshakes and a delivered-word counter. Optional macro:
// IMM_RANGE_CHECK_EN (per-word immediate range error flag).
module instr_pack
  import instr_pack_pkg::*;
#(
  parameter int N = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          immsrc,
  input  logic signed [N-1:0] imm,
  input  logic [6:0]          opcode,
  input  logic [4:0]          rd,
  input  logic [4:0]          rs1,
  input  logic [4:0]          rs2,
  input  logic [2:0]          funct3,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0]        out_instr,
  output logic                out_err,
  output logic [15:0]         word_cnt
);

  logic [N-1:0] instr_p0;
  logic         err_p0;

  imm_pack #(.N(N)) u_imm_pack (
    .immsrc (immsrc),
    .imm    (imm),
    .opcode (opcode),
    .rd     (rd),
    .rs1    (rs1),
    .rs2    (rs2),
    .funct3 (funct3),
    .instr  (instr_p0),
    .err    (err_p0)
  );

  // ---- stage p0 -> p1: packed word enters the FIFO ----
  logic [N-1:0] instr_p1 [FIFO_DEPTH];
  logic         err_p1   [FIFO_DEPTH];
  logic [1:0]   occ;
  logic         wptr;
  logic         rptr;
  logic         vld_p1;
  logic         push;
  logic         pop;

  assign in_ready  = (occ != 2'd2);
  assign vld_p1    = (occ != 2'd0);
  assign out_valid = vld_p1;
  assign push      = in_valid && in_ready;
  assign pop       = vld_p1 && out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ      <= 2'd0;
      wptr     <= 1'b0;
      rptr     <= 1'b0;
      word_cnt <= 16'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop) begin
        rptr     <= ~rptr;
        word_cnt <= word_cnt + 16'd1;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_p1[wptr] <= instr_p0;
      err_p1[wptr]   <= err_p0;
    end
  end

  // Storage is not reset; gating by valid keeps outputs at zero when empty.
  assign out_instr = vld_p1 ? instr_p1[rptr] : '0;
  assign out_err   = vld_p1 ? err_p1[rptr] : 1'b0;

endmodule

// File: doc/instr_pack.md
INSTR_PACK -- requirements
Module: instr_pack

Interface
REQ-001 SHALL have parameter: N, default 32, instruction/immediate width in bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  request carries a field set.
REQ-005 SHALL have port: in_ready  output  1  block accepts the request this cycle.
REQ-006 SHALL have port: immsrc  input  2  format: 00 I, 01 S, 10 B, 11 J.
REQ-007 SHALL have port: imm  input  N  signed byte-offset immediate.
REQ-008 SHALL have ports: opcode input 7; rd, rs1, rs2 input 5 each; funct3 input 3; all are raw instruction fields.
REQ-009 SHALL have port: out_valid  output  1  out_instr is valid.
REQ-010 SHALL have port: out_ready  input  1  consumer takes the word this cycle.
REQ-011 SHALL have port: out_instr  output  N  packed instruction word.
REQ-012 SHALL have port: out_err  output  1  immediate not representable in the chosen format.
REQ-013 SHALL have port: word_cnt  output  16  count of words delivered.

Function
REQ-014 SHALL pack the immediate as the inverse of the core's immediate extender, as follows. I: [31:20]=imm[11:0]. S: [31:25]=imm[11:5] and [11:7]=imm[4:0]. B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11]. J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
REQ-015 SHALL place the remaining fields by format.
- [6:0]=opcode in all formats.
- rd at [11:7] for I and J.
- funct3 at [14:12] and rs1 at [19:15] for I, S and B.
- rs2 at [24:20] for S and B.
- Fields not used by a format are ignored.
REQ-016 SHALL buffer packed words in a 2-entry FIFO.
- A transfer occurs when in_valid && in_ready.
- in_ready = (occupancy < 2).
REQ-017 SHALL drive the word accepted at edge k on out_valid/out_instr after edge k (1-cycle latency). Words SHALL leave in acceptance order.
- out_valid = (occupancy > 0).
- A word is popped on out_valid && out_ready.
REQ-018 SHALL keep out_instr/out_err stable while out_valid && !out_ready.
REQ-019 SHALL handle simultaneous push and pop at occupancy 1 by leaving occupancy at 1 and presenting the new word on the next cycle.
REQ-020 SHALL not push at occupancy 2; a pop there SHALL lower occupancy to 1, and in_ready SHALL rise the following cycle.
REQ-021 SHALL increment word_cnt on each pop and wrap 0xFFFF->0x0000.

Reset
REQ-022 SHALL, while reset is high, asynchronously force: occupancy 0, out_valid 0, in_ready 1, out_instr 0, out_err 0, word_cnt 0.
REQ-023 SHALL discard buffered words on reset mid-operation; the first accept after release SHALL appear on the following cycle.

Configuration
REQ-024 SHALL support macro IMM_RANGE_CHECK_EN.
- Defined: out_err=1 for a word when imm lies outside its format range: I/S [-2048, 2047]; B [-4096, 4094] with imm[0]=0; J [-1048576, 1048574] with imm[0]=0. The word is still packed from the truncated bits, and out_err is stored per FIFO entry.
- Undefined: out_err is constant 0 and imm is truncated silently.

Structure
REQ-025 SHALL define the immsrc encodings IMM_I, IMM_S, IMM_B and IMM_J in a shared package, also used by the decode-side extender and control.
REQ-026 SHALL isolate the combinational field packer, including the range check, in sub-module imm_pack. FIFO, handshake and counter logic stay in instr_pack.

Verification
REQ-027 SHALL check I-format: immsrc=00, imm=0xFFFFFFFF, opcode=0x13, rd=1, rs1=0, funct3=0 -> out_instr=0xFFF00093 one cycle after accept, out_err=0.
REQ-028 SHALL check S and B formats.
- S: imm=8, rs2=2, rs1=1, funct3=2, opcode=0x23 -> 0x0020A423.
- B: imm=0xFFFFFFFC, rs1=rs2=0, funct3=0, opcode=0x63 -> 0xFE000EE3.
REQ-029 SHALL check J-format: imm=0x800, rd=1, opcode=0x6F -> 0x001000EF.
REQ-030 SHALL check backpressure: out_ready=0 with three back-to-back requests -> in_ready=0 after two accepts. Then out_ready=1 -> the two words appear in order, the third is accepted, and word_cnt advances by 1 per pop.
REQ-031 SHALL check the range check with IMM_RANGE_CHECK_EN: I imm=2048 -> out_err=1; B imm=3 -> out_err=1. Without the macro, the same stimulus -> out_err=0.
REQ-032 SHALL check reset mid-operation and counter wrap.
- Assert reset with 2 words buffered -> out_valid=0, word_cnt=0 immediately.
- Preload word_cnt near 0xFFFF and perform 2 pops -> word_cnt wraps to 0x0001.
